// File: rtl/frontend_pkg.sv
// frontend_pkg: shared phase encoding and DAC idle level for the MAX5863 frontend.
package frontend_pkg;
  typedef enum logic {PH_LOW = 1'b0, PH_HIGH = 1'b1} phase_t;
  localparam logic [9:0] DAC_MID_DEFAULT = 10'h000;
endpackage

// File: rtl/frontend_clkgen.sv
// frontend_clkgen: codec clock divider with one-cycle rise/fall event pulses.
module frontend_clkgen
  import frontend_pkg::*;
#(
  parameter int DIV_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] clk_div,
  output logic             max_clk_o,
  output logic             rise,
  output logic             fall
);
  logic [DIV_W-1:0] cnt, div_q, lim;
  logic             wrap;
  phase_t           ph;
  // clk_div is picked up at the start of each half-period and held until the wrap
  assign lim       = (cnt == '0) ? clk_div : div_q;
  assign wrap      = cnt == lim;
  assign rise      = enable && wrap && ph == PH_LOW;
  assign fall      = enable && wrap && ph == PH_HIGH;
  assign max_clk_o = ph == PH_HIGH;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      div_q <= '0;
      ph    <= PH_LOW;
    end else if (!enable) begin
      cnt <= '0;
      ph  <= PH_LOW;
    end else begin
      div_q <= lim;
      cnt   <= wrap ? '0 : cnt + 1'b1;
      if (wrap) ph <= (ph == PH_HIGH) ? PH_LOW : PH_HIGH;
    end
endmodule

// File: rtl/frontend.sv
// frontend: FT245-style byte FIFO to MAX5863 codec bridge (interleaved I/Q DAC and ADC).
module frontend
  import frontend_pkg::*;
#(
  parameter int         DIV_W   = 7,
  parameter logic [9:0] DAC_MID = DAC_MID_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             tx_i_en,
  input  logic             tx_q_en,
  input  logic             rx_i_en,
  input  logic             rx_q_en,
  input  logic             dac_fifo_rdy,
  output logic             dac_fifo_read,
  input  logic [7:0]       dac_fifo_data,
  input  logic             adc_fifo_rdy,
  output logic             adc_fifo_write,
  output logic [7:0]       adc_fifo_data,
  output logic             max_clk_o,
  output logic [9:0]       dac_o,
  input  logic [7:0]       adc_i
);
  logic       rise, fall, first_hi, first_lo, rd_i, rd_q, cap_i, cap_q, i_vld, q_vld, adc_pend;
  logic [7:0] i_hold, q_hold, i_byte, q_byte;
  frontend_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .clk_div  (clk_div),
    .max_clk_o(max_clk_o),
    .rise     (rise),
    .fall     (fall)
  );
  assign rd_i           = enable && first_hi && tx_i_en && dac_fifo_rdy;
  assign rd_q           = enable && first_lo && tx_q_en && dac_fifo_rdy;
  assign dac_fifo_read  = rd_i || rd_q;
  assign adc_fifo_write = enable && adc_pend && adc_fifo_rdy;
  // a byte landing on the phase edge goes straight to the bus
  assign i_byte = cap_i ? dac_fifo_data : i_hold;
  assign q_byte = cap_q ? dac_fifo_data : q_hold;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {first_hi, first_lo, cap_i, cap_q, i_vld, q_vld, adc_pend} <= '0;
      i_hold        <= '0;
      q_hold        <= '0;
      adc_fifo_data <= '0;
      dac_o         <= DAC_MID;
    end else if (!enable) begin
      {first_hi, first_lo, cap_i, cap_q, i_vld, q_vld, adc_pend} <= '0;
      i_hold        <= '0;
      q_hold        <= '0;
      adc_fifo_data <= '0;
      dac_o         <= DAC_MID;
    end else begin
      first_hi <= rise;
      first_lo <= fall;
      cap_i    <= rd_i;
      cap_q    <= rd_q;
      if (cap_i) begin
        i_hold <= dac_fifo_data;
        i_vld  <= 1'b1;
      end
      if (cap_q) begin
        q_hold <= dac_fifo_data;
        q_vld  <= 1'b1;
      end
      if (rise) dac_o <= (tx_i_en && (cap_i || i_vld)) ? {i_byte, 2'b00} : DAC_MID;
      else if (fall) dac_o <= (tx_q_en && (cap_q || q_vld)) ? {q_byte, 2'b00} : DAC_MID;
      // I is sampled as the codec clock falls, Q as it rises
      adc_pend <= (fall && rx_i_en) || (rise && rx_q_en);
      if ((fall && rx_i_en) || (rise && rx_q_en)) adc_fifo_data <= adc_i;
    end
endmodule

// File: tb/tb_frontend.sv
// tb_frontend: randomized scoreboard bench for frontend against a phase-level reference model.
module tb_frontend;
  localparam logic [9:0] MID = 10'h000;
  localparam int NTX = 3000;

  logic       clk = 0, rst_n = 0, enable = 0;
  logic [6:0] clk_div = 0;
  logic       tx_i_en = 0, tx_q_en = 0, rx_i_en = 0, rx_q_en = 0;
  logic       dac_fifo_rdy = 0, adc_fifo_rdy = 0;
  logic [7:0] dac_fifo_data = 0, adc_i = 0;
  logic       dac_fifo_read, adc_fifo_write, max_clk_o;
  logic [7:0] adc_fifo_data;
  logic [9:0] dac_o;

  always #5 clk = ~clk;

  frontend dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .clk_div       (clk_div),
    .tx_i_en       (tx_i_en),
    .tx_q_en       (tx_q_en),
    .rx_i_en       (rx_i_en),
    .rx_q_en       (rx_q_en),
    .dac_fifo_rdy  (dac_fifo_rdy),
    .dac_fifo_read (dac_fifo_read),
    .dac_fifo_data (dac_fifo_data),
    .adc_fifo_rdy  (adc_fifo_rdy),
    .adc_fifo_write(adc_fifo_write),
    .adc_fifo_data (adc_fifo_data),
    .max_clk_o     (max_clk_o),
    .dac_o         (dac_o),
    .adc_i         (adc_i)
  );

  typedef struct {int ph; bit ch; logic [7:0] b;} dent_t;
  typedef struct {logic lvl; logic [9:0] dac; logic rd; logic wr; logic [7:0] ad;} cyc_t;

  int compared = 0, mismatched = 0;
  int tx_mode = 0, adc_mode = 0;
  logic [7:0] tx_list[NTX];
  logic [7:0] env_q[$];
  logic [7:0] adc_q[$];
  cyc_t       cyc_q[$];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      if (mismatched <= 40) $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
    end
  endtask

  // TX/RX FIFO environment: serves popped bytes one cycle after a read, randomizes readiness and ADC bus
  initial begin
    logic rs;
    forever begin
      @(negedge clk);
      rs = dac_fifo_read;
      @(posedge clk);
      #1;
      if (rs && env_q.size() > 0) dac_fifo_data = env_q.pop_front();
      else dac_fifo_data = 8'($urandom);
      dac_fifo_rdy = env_q.size() > 0 && (tx_mode == 1 || (tx_mode == 2 && $urandom_range(0, 3) != 0));
      adc_fifo_rdy = adc_mode == 1 || (adc_mode == 2 && $urandom_range(0, 3) != 0);
      adc_i = 8'($urandom);
    end
  end

  // Reference model: codec half-periods are numbered; a byte read in half-period k is on the bus in k+2
  initial begin
    bit         p_rst = 0, p_en = 0, p_ti = 0, p_tq = 0, p_ri = 0, p_rq = 0;
    int         p_div = 0, n = 0, j = 0, tidx = 0;
    logic [7:0] p_adc = 0, cur_i = 0, cur_q = 0, adat = 0;
    bit         lvl = 0, first = 0, vi = 0, vq = 0, apend = 0, tog, erd, ewr;
    logic [9:0] edac = MID;
    dent_t      dq[$];
    dent_t      e;
    forever begin
      @(negedge clk);
      if (!p_rst || !p_en || !rst_n) begin
        n = 0; j = 0; lvl = 0; first = 0; vi = 0; vq = 0; apend = 0; adat = 0; edac = MID;
        dq.delete();
      end else begin
        tog = ((n + 1) % (p_div + 1)) == 0;
        n++;
        first = 0;
        apend = 0;
        if (tog) begin
          if (lvl ? p_ri : p_rq) begin
            apend = 1;
            adat  = p_adc;
          end
          lvl = !lvl;
          j++;
          first = 1;
          while (dq.size() > 0 && dq[0].ph <= j - 2) begin
            e = dq.pop_front();
            if (e.ch) begin cur_q = e.b; vq = 1; end
            else begin cur_i = e.b; vi = 1; end
          end
          edac = lvl ? ((p_ti && vi) ? {cur_i, 2'b00} : MID) : ((p_tq && vq) ? {cur_q, 2'b00} : MID);
        end
      end
      erd = enable && rst_n && first && (lvl ? tx_i_en : tx_q_en) && dac_fifo_rdy;
      if (erd && tidx < NTX) begin
        dq.push_back('{j, !lvl, tx_list[tidx]});
        tidx++;
      end
      ewr = enable && rst_n && apend && adc_fifo_rdy;
      if (ewr) adc_q.push_back(adat);
      cyc_q.push_back('{lvl, edac, erd, ewr, adat});
      p_rst = rst_n; p_en = enable; p_div = int'(clk_div);
      p_ti = tx_i_en; p_tq = tx_q_en; p_ri = rx_i_en; p_rq = rx_q_en; p_adc = adc_i;
    end
  end

  // Monitor: pops the per-cycle expectation and the ADC push queue
  initial begin
    cyc_t c;
    forever begin
      @(negedge clk);
      #1;
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        chk("max_clk", max_clk_o, c.lvl);
        chk("dac_o", dac_o, c.dac);
        chk("dac_read", dac_fifo_read, c.rd);
        chk("adc_write", adc_fifo_write, c.wr);
        chk("adc_data_reg", adc_fifo_data, c.ad);
        if (adc_fifo_write) begin
          if (adc_q.size() > 0) chk("adc_push_byte", adc_fifo_data, adc_q.pop_front());
          else chk("adc_push_unexpected", adc_fifo_write, 1'b0);
        end
      end
    end
  end

  task automatic seg(input int d, input bit ti, tq, ri, rq, input int tm, am, cyc);
    enable = 0;
    repeat (2) @(posedge clk);
    #1;
    clk_div = 7'(d);
    tx_i_en = ti; tx_q_en = tq; rx_i_en = ri; rx_q_en = rq;
    tx_mode = tm; adc_mode = am;
    enable = 1;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NTX; i++) tx_list[i] = (i < 4) ? 8'(i + 1) : 8'($urandom);
    for (int i = 0; i < NTX; i++) env_q.push_back(tx_list[i]);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    seg(0, 1, 1, 0, 0, 1, 0, 40);
    seg(3, 0, 0, 1, 1, 0, 1, 60);
    seg(1, 1, 0, 1, 0, 1, 1, 60);
    seg(2, 1, 1, 1, 1, 1, 1, 60);
    tx_mode = 0;
    repeat (100) @(posedge clk);
    #1;
    tx_mode = 1;
    repeat (80) @(posedge clk);
    #1;
    seg(3, 1, 1, 1, 1, 2, 1, 40);
    adc_mode = 0;
    repeat (40) @(posedge clk);
    #1;
    adc_mode = 1;
    repeat (60) @(posedge clk);
    #2;
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (60) @(posedge clk);
    #1;
    for (int s = 0; s < 20; s++) begin
      seg($urandom_range(0, 5), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(20, 90));
      if (s % 5 == 2) begin
        #2;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (30) @(posedge clk);
        #1;
      end
    end
    enable = 0;
    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
